// File: rtl/aixh_mxc_upper_ptile_mac.sv
// aixh_mxc_upper_ptile_mac
// MxConv upper processing tile: NCELLS MAC cells fed by a left-to-right
// command shift chain, with a right-to-left result chain for draining.
//
// Ports
//   aixh_core_clk2x  : clock
//   aixh_core_rstn   : asynchronous active-low reset
//   i_uqt_dat        : per-cell signed vertical operand (slice x -> cell x)
//   o_ipt_vld        : per cell {last, valid} of the registered product
//   o_ipt_dat        : per-cell registered signed product
//   i_upt_cmd        : command from the left neighbour / controller
//   o_upt_cmd        : command to the right neighbour
//   i_upt_vld/dat    : backward result stream from the right neighbour
//   o_upt_vld/dat    : backward result stream to the left neighbour
//   o_err            : sticky backward-chain collision flag
module aixh_mxc_upper_ptile_mac #(
  parameter int NCELLS     = 4,
  parameter int TILE_INDEX = 0,
  parameter int DAT_W      = 8,
  parameter int COEF_W     = 8,
  parameter int ACC_W      = 24,
  localparam int PROD_W    = DAT_W + COEF_W,
  localparam int CMD_W     = 12 + COEF_W
) (
  input  logic                       aixh_core_clk2x,
  input  logic                       aixh_core_rstn,
  input  logic [NCELLS*DAT_W-1:0]    i_uqt_dat,
  output logic [NCELLS*2-1:0]        o_ipt_vld,
  output logic [NCELLS*PROD_W-1:0]   o_ipt_dat,
  input  logic [CMD_W-1:0]           i_upt_cmd,
  output logic [CMD_W-1:0]           o_upt_cmd,
  input  logic                       i_upt_vld,
  input  logic [ACC_W-1:0]           i_upt_dat,
  output logic                       o_upt_vld,
  output logic [ACC_W-1:0]           o_upt_dat,
  output logic                       o_err
);

  localparam logic [2:0] OP_LOAD_BC = 3'd1;
  localparam logic [2:0] OP_LOAD_UC = 3'd2;
  localparam logic [2:0] OP_MAC     = 3'd3;
  localparam logic [2:0] OP_MAC_LST = 3'd4;
  localparam logic [2:0] OP_DRAIN   = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;

  logic [CMD_W-1:0]         cmd_in   [NCELLS];
  logic [CMD_W-1:0]         cmd_q    [NCELLS];
  logic signed [COEF_W-1:0] coef_q   [NCELLS];
  logic [ACC_W-1:0]         acc_q    [NCELLS];
  logic [PROD_W-1:0]        prod_q   [NCELLS];
  logic [1:0]               pvld_q   [NCELLS];
  // Backward chain entries are {valid, data}; bwd_src[x] is what shifts into bwd_q[x].
  logic [ACC_W:0]           bwd_q    [NCELLS];
  logic [ACC_W:0]           bwd_src  [NCELLS];
  logic [NCELLS-1:0]        inject;
  logic [NCELLS-1:0]        collide;

  genvar gi;
  generate
    for (gi = 0; gi < NCELLS; gi++) begin : g_cell
      localparam int GIDX = TILE_INDEX * NCELLS + gi;

      logic                     c_vld;
      logic [2:0]               c_op;
      logic [7:0]               c_idx;
      logic [COEF_W-1:0]        c_pay;
      logic signed [DAT_W-1:0]  dat;
      logic signed [PROD_W-1:0] prod;
      logic signed [ACC_W-1:0]  prod_ext;
      logic                     do_mac;

      if (gi == 0) begin : g_first
        assign cmd_in[gi] = i_upt_cmd;
      end else begin : g_rest
        assign cmd_in[gi] = cmd_q[gi-1];
      end

      if (gi == NCELLS - 1) begin : g_last
        assign bwd_src[gi] = {i_upt_vld, i_upt_dat};
      end else begin : g_mid
        assign bwd_src[gi] = bwd_q[gi+1];
      end

      assign c_vld = cmd_in[gi][CMD_W-1];
      assign c_op  = cmd_in[gi][CMD_W-2:CMD_W-4];
      assign c_idx = cmd_in[gi][CMD_W-5:COEF_W];
      assign c_pay = cmd_in[gi][COEF_W-1:0];

      assign dat      = i_uqt_dat[gi*DAT_W +: DAT_W];
      // coef_q is the pre-edge value, so a LOAD just ahead of a MAC is honoured.
      assign prod     = PROD_W'(coef_q[gi]) * PROD_W'(dat);
      assign prod_ext = ACC_W'(prod);
      assign do_mac   = c_vld && ((c_op == OP_MAC) || (c_op == OP_MAC_LST));

      assign inject[gi]  = c_vld && (c_op == OP_DRAIN);
      // Local drain overrides whatever was shifting in; flag the loss.
      assign collide[gi] = inject[gi] && bwd_src[gi][ACC_W];

      always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
          cmd_q[gi]  <= '0;
          coef_q[gi] <= '0;
          acc_q[gi]  <= '0;
          prod_q[gi] <= '0;
          pvld_q[gi] <= '0;
          bwd_q[gi]  <= '0;
        end else begin
          cmd_q[gi]  <= cmd_in[gi];
          bwd_q[gi]  <= inject[gi] ? {1'b1, acc_q[gi]} : bwd_src[gi];
          pvld_q[gi] <= 2'b00;
          if (do_mac) begin
            prod_q[gi] <= prod;
            pvld_q[gi] <= {(c_op == OP_MAC_LST), 1'b1};
            acc_q[gi]  <= acc_q[gi] + prod_ext;
          end
          if (c_vld) begin
            case (c_op)
              OP_LOAD_BC: coef_q[gi] <= c_pay;
              OP_LOAD_UC: if (c_idx == 8'(GIDX)) coef_q[gi] <= c_pay;
              OP_DRAIN,
              OP_CLEAR:   acc_q[gi] <= '0;
              default:    ;
            endcase
          end
        end
      end

      assign o_ipt_vld[gi*2 +: 2]           = pvld_q[gi];
      assign o_ipt_dat[gi*PROD_W +: PROD_W] = prod_q[gi];
    end
  endgenerate

  always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
    if (!aixh_core_rstn) begin
      o_err <= 1'b0;
    end else if (|collide) begin
      o_err <= 1'b1;
    end
  end

  assign o_upt_cmd = cmd_q[NCELLS-1];
  assign o_upt_vld = bwd_q[0][ACC_W];
  assign o_upt_dat = bwd_q[0][ACC_W-1:0];

endmodule

// File: tb/tb_aixh_mxc_upper_ptile_mac.sv
// Directed bench: two chained 4-cell tiles (tile 0 and tile 1) plus a
// single-cell tile with a 16-bit accumulator for the wrap case.
module tb_aixh_mxc_upper_ptile_mac;

  localparam logic [2:0] LBC = 3'd1;
  localparam logic [2:0] LUC = 3'd2;
  localparam logic [2:0] MAC = 3'd3;
  localparam logic [2:0] MCL = 3'd4;
  localparam logic [2:0] DRN = 3'd5;
  localparam logic [2:0] CLR = 3'd6;

  logic        clk;
  logic        rstn;
  logic [19:0] cmd, cmd01, cmd_out1;
  logic [31:0] dat0, dat1;
  logic [7:0]  ipv0, ipv1;
  logic [63:0] ipd0, ipd1;
  logic        up_vld1;
  logic [23:0] up_dat1;
  logic        v10, ov;
  logic [23:0] d10, od;
  logic        err0, err1;

  logic [19:0] cmdw, cmdw_out;
  logic [7:0]  datw;
  logic [1:0]  ipvw;
  logic [15:0] ipdw;
  logic        up_vldw, ovw, errw;
  logic [15:0] up_datw, odw;

  int checks   = 0;
  int failures = 0;

  aixh_mxc_upper_ptile_mac #(.NCELLS(4), .TILE_INDEX(0)) u0 (
    .aixh_core_clk2x(clk), .aixh_core_rstn(rstn),
    .i_uqt_dat(dat0), .o_ipt_vld(ipv0), .o_ipt_dat(ipd0),
    .i_upt_cmd(cmd), .o_upt_cmd(cmd01),
    .i_upt_vld(v10), .i_upt_dat(d10),
    .o_upt_vld(ov), .o_upt_dat(od), .o_err(err0));

  aixh_mxc_upper_ptile_mac #(.NCELLS(4), .TILE_INDEX(1)) u1 (
    .aixh_core_clk2x(clk), .aixh_core_rstn(rstn),
    .i_uqt_dat(dat1), .o_ipt_vld(ipv1), .o_ipt_dat(ipd1),
    .i_upt_cmd(cmd01), .o_upt_cmd(cmd_out1),
    .i_upt_vld(up_vld1), .i_upt_dat(up_dat1),
    .o_upt_vld(v10), .o_upt_dat(d10), .o_err(err1));

  aixh_mxc_upper_ptile_mac #(.NCELLS(1), .TILE_INDEX(0), .ACC_W(16)) uw (
    .aixh_core_clk2x(clk), .aixh_core_rstn(rstn),
    .i_uqt_dat(datw), .o_ipt_vld(ipvw), .o_ipt_dat(ipdw),
    .i_upt_cmd(cmdw), .o_upt_cmd(cmdw_out),
    .i_upt_vld(up_vldw), .i_upt_dat(up_datw),
    .o_upt_vld(ovw), .o_upt_dat(odw), .o_err(errw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [2:0] op, input logic [7:0] idx,
                                     input logic [7:0] coef);
    return {1'b1, op, idx, coef};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic        ev;
  logic [23:0] ed;

  initial begin
    // Reset with arbitrary inputs applied
    rstn = 1'b0;
    cmd = mk(MAC, 8'h5a, 8'h33); dat0 = 32'hdeadbeef; dat1 = 32'h12345678;
    up_vld1 = 1'b1; up_dat1 = 24'habcdef;
    cmdw = mk(MAC, 8'h00, 8'h11); datw = 8'h22; up_vldw = 1'b1; up_datw = 16'h1234;
    repeat (3) tick();
    chk("rst_cmd0", cmd01, 0);
    chk("rst_cmd1", cmd_out1, 0);
    chk("rst_ipv0", ipv0, 0);
    chk("rst_ipd0", ipd0, 0);
    chk("rst_upv", ov, 0);
    chk("rst_upd", od, 0);
    chk("rst_err", err0, 0);
    chk("rst_wrap_upv", ovw, 0);

    cmd = '0; dat0 = '0; dat1 = '0; up_vld1 = 1'b0; up_dat1 = '0;
    cmdw = '0; datw = '0; up_vldw = 1'b0; up_datw = '0;
    rstn = 1'b1;
    tick();

    // Command latency; vld=0 command is forwarded but not executed
    cmd = 20'h3A53C;
    tick();
    cmd = '0;
    chk("novld_ignored", ipv0, 0);
    tick(); tick();
    chk("lat_early", cmd01, 0);
    tick();
    chk("lat_cmd0", cmd01, 20'h3A53C);
    tick();
    chk("lat_cmd0_gone", cmd01, 0);
    tick(); tick(); tick();
    chk("lat_cmd1", cmd_out1, 20'h3A53C);

    // Broadcast load then MAC / MAC_LAST
    cmd = mk(LBC, 8'd0, 8'd3);
    tick();
    cmd = mk(MAC, 8'd0, 8'd0); dat0 = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    chk("bc_c0_dat", ipd0[0 +: 16], 16'd3);
    chk("bc_c0_vld", ipv0[0 +: 2], 2'b01);
    cmd = mk(MCL, 8'd0, 8'd0);
    tick();
    chk("bc_c1_dat", ipd0[16 +: 16], 16'd6);
    chk("bc_c1_vld", ipv0[2 +: 2], 2'b01);
    chk("bc_c0_last", ipv0[0 +: 2], 2'b11);
    cmd = '0;
    tick();
    chk("bc_c2_dat", ipd0[32 +: 16], 16'd9);
    chk("bc_c2_vld", ipv0[4 +: 2], 2'b01);
    chk("bc_c0_vld_drop", ipv0[0 +: 2], 2'b00);
    chk("bc_c0_hold", ipd0[0 +: 16], 16'd3);
    tick();
    chk("bc_c3_dat", ipd0[48 +: 16], 16'd12);
    chk("bc_c3_vld", ipv0[6 +: 2], 2'b01);
    tick();
    chk("bc_c3_last", ipv0[6 +: 2], 2'b11);
    tick();
    chk("bc_all_idle", ipv0, 0);

    // Unicast into tile 1 cell 2 (global index 6)
    dat1 = {4{8'd5}};
    cmd = mk(LUC, 8'd6, 8'hFE);
    tick();
    cmd = mk(MAC, 8'd0, 8'd0);
    tick();
    cmd = '0;
    repeat (10) tick();
    chk("uc_t1c0", ipd1[0 +: 16], 16'd15);
    chk("uc_t1c1", ipd1[16 +: 16], 16'd15);
    chk("uc_t1c2", ipd1[32 +: 16], 16'hFFF6);
    chk("uc_t1c3", ipd1[48 +: 16], 16'd15);
    chk("uc_t0c2", ipd0[32 +: 16], 16'd9);

    // idx=2 hits tile 0 cell 2 only
    cmd = mk(LUC, 8'd2, 8'd7);
    tick();
    dat1 = {4{8'd1}};
    cmd = mk(MAC, 8'd0, 8'd0);
    tick();
    cmd = '0;
    repeat (10) tick();
    chk("uc2_t1c0", ipd1[0 +: 16], 16'd3);
    chk("uc2_t1c2", ipd1[32 +: 16], 16'hFFFE);
    chk("uc2_t1c3", ipd1[48 +: 16], 16'd3);
    chk("uc2_t0c2", ipd0[32 +: 16], 16'd21);
    chk("uc2_t0c1", ipd0[16 +: 16], 16'd6);

    // Drain across the two chained tiles
    cmd = mk(CLR, 8'd0, 8'd0);
    tick();
    cmd = mk(LBC, 8'd0, 8'd2);
    tick();
    dat0 = {8'd4, 8'd3, 8'd2, 8'd1};
    dat1 = {8'd8, 8'd7, 8'd6, 8'd5};
    cmd = mk(MAC, 8'd0, 8'd0);
    repeat (3) tick();
    cmd = '0;
    repeat (10) tick();

    cmd = mk(DRN, 8'd0, 8'd0);
    for (int off = 0; off <= 16; off++) begin
      tick();
      cmd = '0;
      ev = ((off % 2) == 0) && (off <= 14);
      ed = (off <= 6) ? 24'(6 * (off / 2 + 1)) : 24'(30 + 6 * (off / 2 - 4));
      chk($sformatf("drain1_vld_%0d", off), ov, ev);
      if (ev) chk($sformatf("drain1_dat_%0d", off), od, ed);
    end
    chk("drain1_err0", err0, 0);
    chk("drain1_err1", err1, 0);

    cmd = mk(DRN, 8'd0, 8'd0);
    for (int off = 0; off <= 16; off++) begin
      tick();
      cmd = '0;
      ev = ((off % 2) == 0) && (off <= 14);
      chk($sformatf("drain2_vld_%0d", off), ov, ev);
      if (ev) chk($sformatf("drain2_dat_%0d", off), od, 0);
    end
    chk("drain2_err0", err0, 0);

    // Collision: DRAINs only 2 cycles apart
    cmd = mk(DRN, 8'd0, 8'd0);
    tick();
    cmd = '0;
    tick();
    cmd = mk(DRN, 8'd0, 8'd0);
    tick();
    cmd = '0;
    repeat (20) tick();
    chk("coll_err0", err0, 1);
    chk("coll_err1", err1, 1);
    repeat (5) tick();
    chk("coll_err0_sticky", err0, 1);
    rstn = 1'b0;
    #1;
    chk("coll_err0_rst", err0, 0);
    chk("coll_err1_rst", err1, 0);
    #2;
    rstn = 1'b1;
    tick();

    // 16-bit accumulator: 0x4000 + 0x3F01 + 0xFE + 1 = 0x8000
    cmdw = mk(LBC, 8'd0, 8'h80);
    tick();
    cmdw = mk(MAC, 8'd0, 8'd0); datw = 8'h80;
    tick();
    chk("wrap_prod_neg_neg", ipdw, 16'h4000);
    cmdw = mk(LBC, 8'd0, 8'd127);
    tick();
    cmdw = mk(MAC, 8'd0, 8'd0); datw = 8'd127;
    tick();
    chk("wrap_prod_127sq", ipdw, 16'h3F01);
    datw = 8'd2;
    tick();
    cmdw = mk(LBC, 8'd0, 8'd1);
    tick();
    cmdw = mk(MAC, 8'd0, 8'd0); datw = 8'd1;
    tick();
    cmdw = mk(DRN, 8'd0, 8'd0);
    tick();
    cmdw = '0;
    chk("wrap_vld", ovw, 1);
    chk("wrap_dat", odw, 16'h8000);
    tick();
    chk("wrap_vld_drop", ovw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
